// File: rtl/mm_result_drain_pkg.sv
// Shared definitions for the matmul result drain: default geometry, drain FSM states
// and counter-width helpers.
package mm_result_drain_pkg;

  localparam int unsigned DRAIN_LANES      = 2;
  localparam int unsigned DRAIN_LANE_WIDTH = 64;
  localparam int unsigned DRAIN_WORD_WIDTH = 16;
  localparam int unsigned WORDS_PER_LANE   = DRAIN_LANE_WIDTH / DRAIN_WORD_WIDTH;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // Counters are always at least one bit wide, even for a single lane or word.
  function automatic int unsigned lane_cnt_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  function automatic int unsigned word_cnt_w(input int unsigned lane_width,
                                             input int unsigned word_width);
    int unsigned words;
    words = lane_width / word_width;
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mm_result_drain_if.sv
// Capture-side and stream-side signals of the result drain; slave is the drain's view,
// master the view of the producer/consumer environment.
interface mm_result_drain_if
  import mm_result_drain_pkg::*;
#(
  parameter int unsigned LANES      = DRAIN_LANES,
  parameter int unsigned LANE_WIDTH = DRAIN_LANE_WIDTH,
  parameter int unsigned WORD_WIDTH = DRAIN_WORD_WIDTH
) ();

  localparam int unsigned LANE_CW = lane_cnt_w(LANES);

  logic                  in_valid;
  logic [LANE_WIDTH-1:0] in_data [LANES];
  logic                  in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic [LANE_CW-1:0]    out_lane;
  logic                  out_last;
  logic                  block_done;
  logic                  overflow;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, block_done, overflow
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, block_done, overflow
  );

endinterface

// File: rtl/mm_drain_bank.sv
// One ping-pong bank: captures a whole result block in one cycle and exposes a
// word-select read mux over it.
module mm_drain_bank
  import mm_result_drain_pkg::*;
#(
  parameter int unsigned LANES      = DRAIN_LANES,
  parameter int unsigned LANE_WIDTH = DRAIN_LANE_WIDTH,
  parameter int unsigned WORD_WIDTH = DRAIN_WORD_WIDTH,
  localparam int unsigned LANE_CW   = lane_cnt_w(LANES),
  localparam int unsigned WORD_CW   = word_cnt_w(LANE_WIDTH, WORD_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [LANE_WIDTH-1:0] wdata_i [LANES],
  input  logic [LANE_CW-1:0]    lane_sel_i,
  input  logic [WORD_CW-1:0]    word_sel_i,
  output logic [WORD_WIDTH-1:0] rd_word_c_o
);

  logic [LANE_WIDTH-1:0] mem_q [LANES];

  // Data storage carries no reset; validity lives in the owner's full flags.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q <= wdata_i;
    end
  end

  always_comb begin
    rd_word_c_o = mem_q[lane_sel_i][32'(word_sel_i) * WORD_WIDTH +: WORD_WIDTH];
  end

endmodule

// File: rtl/mm_result_drain.sv
// Result drain: captures matmul output blocks into a two-bank ping-pong store and
// streams them out word by word, LSB word and lane 0 first.
module mm_result_drain
  import mm_result_drain_pkg::*;
#(
  parameter int unsigned LANES      = DRAIN_LANES,
  parameter int unsigned LANE_WIDTH = DRAIN_LANE_WIDTH,
  parameter int unsigned WORD_WIDTH = DRAIN_WORD_WIDTH
) (
  input logic              clk,
  input logic              rst,
  mm_result_drain_if.slave bus
);

  localparam int unsigned WPL     = LANE_WIDTH / WORD_WIDTH;
  localparam int unsigned LANE_CW = lane_cnt_w(LANES);
  localparam int unsigned WORD_CW = word_cnt_w(LANE_WIDTH, WORD_WIDTH);
  localparam logic [LANE_CW-1:0] LANE_MAX = LANE_CW'(LANES - 1);
  localparam logic [WORD_CW-1:0] WORD_MAX = WORD_CW'(WPL - 1);

  if ((LANE_WIDTH % WORD_WIDTH) != 0) begin : g_bad_word_width
    $error("mm_result_drain: LANE_WIDTH must be an integer multiple of WORD_WIDTH");
  end

  drain_state_t       state_q, state_d;
  logic [1:0]         full_q, full_d;
  logic               wr_sel_q, wr_sel_d;
  logic               rd_sel_q, rd_sel_d;
  logic [WORD_CW-1:0] word_cnt_q, word_cnt_d;
  logic [LANE_CW-1:0] lane_cnt_q, lane_cnt_d;
  logic               overflow_q, overflow_d;
  logic               block_done_q, block_done_d;

  logic                  cap_c, drop_c, hs_c, last_c, in_ready_c;
  logic [1:0]            bank_we_c;
  logic [WORD_WIDTH-1:0] rd_word_c [2];

  // Readiness comes only from registered flags, so a bank freed this cycle is not reusable yet.
  assign in_ready_c = ~&full_q;
  assign cap_c      = bus.in_valid && in_ready_c;
  assign drop_c     = bus.in_valid && !in_ready_c;
  assign hs_c       = (state_q == DRAIN) && bus.out_ready;
  assign last_c     = (lane_cnt_q == LANE_MAX) && (word_cnt_q == WORD_MAX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we_c[b] = cap_c && (wr_sel_q == 1'(b));

    mm_drain_bank #(
      .LANES      (LANES),
      .LANE_WIDTH (LANE_WIDTH),
      .WORD_WIDTH (WORD_WIDTH)
    ) u_bank (
      .clk_i       (clk),
      .we_i        (bank_we_c[b]),
      .wdata_i     (bus.in_data),
      .lane_sel_i  (lane_cnt_q),
      .word_sel_i  (word_cnt_q),
      .rd_word_c_o (rd_word_c[b])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      full_q       <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      word_cnt_q   <= '0;
      lane_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      word_cnt_q   <= word_cnt_d;
      lane_cnt_q   <= lane_cnt_d;
      overflow_q   <= overflow_d;
      block_done_q <= block_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    full_d       = full_q;
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    word_cnt_d   = word_cnt_q;
    lane_cnt_d   = lane_cnt_q;
    overflow_d   = overflow_q || drop_c;
    block_done_d = 1'b0;

    if (cap_c) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = ~wr_sel_q;
    end

    if (hs_c) begin
      if (last_c) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
        word_cnt_d       = '0;
        lane_cnt_d       = '0;
        block_done_d     = 1'b1;
      end else if (word_cnt_q == WORD_MAX) begin
        word_cnt_d = '0;
        lane_cnt_d = lane_cnt_q + LANE_CW'(1);
      end else begin
        word_cnt_d = word_cnt_q + WORD_CW'(1);
      end
    end

    // Looking at next-cycle fullness gives capture+1 latency and no bubble between blocks.
    unique case (state_q)
      IDLE: begin
        if (full_d[rd_sel_q]) state_d = DRAIN;
      end
      DRAIN: begin
        if (hs_c && last_c) state_d = full_d[~rd_sel_q] ? DRAIN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = (state_q == DRAIN);
  assign bus.out_data   = (state_q == DRAIN) ? rd_word_c[rd_sel_q] : '0;
  assign bus.out_lane   = lane_cnt_q;
  assign bus.out_last   = (state_q == DRAIN) && last_c;
  assign bus.block_done = block_done_q;
  assign bus.overflow   = overflow_q;

endmodule
